icache_bank_rr_arbiter: RTL and testbench

Request-side arbiter placed in front of one instruction-cache bank in the icache interconnect. It shares the bank among `N_CORES` fetch ports with round-robin priority and holds the chosen request stable until the bank grants it. It also records the ID of every granted request in an in-order FIFO and routes each bank response back to that core. Its per-core response outputs feed the per-core response OR-trees that merge bank responses.

---
 rtl/icache_intc_pkg.sv | 28 ++
 rtl/icache_id_fifo.sv | 54 +++++
 rtl/icache_bank_rr_arbiter.sv | 97 +++++++++
 tb/tb_icache_bank_rr_arbiter.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/icache_intc_pkg.sv
// rtl/icache_intc_pkg.sv - shared types and the wrapping priority search for the icache interconnect
package icache_intc_pkg;

   localparam int unsigned DEF_N_CORES = 8;
   localparam int unsigned MAX_SEARCH  = 32;

   typedef enum logic {ARB = 1'b0, LOCK = 1'b1} arb_state_e;
   typedef logic [$clog2(DEF_N_CORES)-1:0] core_id_t;

   // First set bit of req at or after ptr, wrapping at n; found stays 0 when nothing requests.
   function automatic int unsigned rr_search(input logic [MAX_SEARCH-1:0] req,
                                             input int unsigned           n,
                                             input int unsigned           ptr,
                                             output logic                 found);
      int unsigned idx;
      rr_search = 0;
      found     = 1'b0;
      for (int unsigned i = 0; i < MAX_SEARCH; i++) begin
         idx = ptr + i;
         if (idx >= n) idx = idx - n;
         if (!found && (i < n) && req[idx[4:0]]) begin
            found     = 1'b1;
            rr_search = idx;
         end
      end
   endfunction

endpackage

// File: rtl/icache_id_fifo.sv
// rtl/icache_id_fifo.sv - in-order FIFO of granted core IDs awaiting their bank response
module icache_id_fifo #(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned WIDTH = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [CNT_W-1:0] count;
   logic             do_push, do_pop;

   function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign head    = mem[rd_ptr];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wrap_inc(wr_ptr);
         if (do_pop)  rd_ptr <= wrap_inc(rd_ptr);
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/icache_bank_rr_arbiter.sv
// rtl/icache_bank_rr_arbiter.sv - round-robin fetch arbiter for one icache bank with in-order response routing
module icache_bank_rr_arbiter
   import icache_intc_pkg::*;
#(
   parameter int unsigned N_CORES         = 8,
   parameter int unsigned ADDR_WIDTH      = 32,
   parameter int unsigned DATA_WIDTH      = 32,
   parameter int unsigned MAX_OUTSTANDING = 2
) (
   input  logic                                clk_i,
   input  logic                                rst_ni,
   input  logic [N_CORES-1:0]                  core_req_i,
   input  logic [N_CORES-1:0][ADDR_WIDTH-1:0]  core_addr_i,
   output logic [N_CORES-1:0]                  core_gnt_o,
   output logic [N_CORES-1:0]                  core_r_valid_o,
   output logic [DATA_WIDTH-1:0]               core_r_rdata_o,
   output logic                                bank_req_o,
   output logic [ADDR_WIDTH-1:0]               bank_addr_o,
   input  logic                                bank_gnt_i,
   input  logic                                bank_r_valid_i,
   input  logic [DATA_WIDTH-1:0]               bank_r_rdata_i,
   output logic                                spurious_rsp_o
);

   localparam int unsigned ID_W = $clog2(N_CORES);

   arb_state_e      state, state_next;
   logic [ID_W-1:0] rr_ptr, lock_id, winner, rr_winner, fifo_head;
   logic            rr_found, winner_valid, handshake, rsp_pop;
   logic            fifo_full, fifo_empty;
   int unsigned     rr_idx;

   always_comb begin
      rr_found  = 1'b0;
      rr_idx    = rr_search(MAX_SEARCH'(core_req_i), N_CORES, 32'(rr_ptr), rr_found);
      rr_winner = ID_W'(rr_idx);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state <= ARB;
      else         state <= state_next;
   end

   // A stalled request locks its core so the bank sees a stable request until the grant.
   always_comb begin
      state_next = state;
      case (state)
         ARB:     if (bank_req_o && !bank_gnt_i) state_next = LOCK;
         LOCK:    if (handshake) state_next = ARB;
         default: state_next = ARB;
      endcase
   end

   always_comb begin
      winner         = (state == LOCK) ? lock_id : rr_winner;
      winner_valid   = (state == LOCK) || rr_found;
      bank_req_o     = winner_valid && !fifo_full;
      bank_addr_o    = winner_valid ? core_addr_i[winner] : '0;
      handshake      = bank_req_o && bank_gnt_i;
      core_gnt_o     = '0;
      if (handshake) core_gnt_o[winner] = 1'b1;
      rsp_pop        = bank_r_valid_i && !fifo_empty;
      core_r_valid_o = '0;
      if (rsp_pop) core_r_valid_o[fifo_head] = 1'b1;
      core_r_rdata_o = rsp_pop ? bank_r_rdata_i : '0;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rr_ptr         <= '0;
         lock_id        <= '0;
         spurious_rsp_o <= 1'b0;
      end else begin
         if (handshake)
            rr_ptr <= (winner == ID_W'(N_CORES - 1)) ? '0 : winner + 1'b1;
         if ((state == ARB) && bank_req_o && !bank_gnt_i)
            lock_id <= winner;
         if (bank_r_valid_i && fifo_empty)
            spurious_rsp_o <= 1'b1;
      end
   end

   icache_id_fifo #(
      .DEPTH (MAX_OUTSTANDING),
      .WIDTH (ID_W)
   ) u_id_fifo (
      .clk   (clk_i),
      .rst_n (rst_ni),
      .push  (handshake),
      .wdata (winner),
      .pop   (rsp_pop),
      .full  (fifo_full),
      .empty (fifo_empty),
      .head  (fifo_head)
   );

endmodule

// File: tb/tb_icache_bank_rr_arbiter.sv
// tb/tb_icache_bank_rr_arbiter.sv - self-checking bench for icache_bank_rr_arbiter
module tb_icache_bank_rr_arbiter;

   localparam int N    = 8;
   localparam int AW   = 32;
   localparam int DW   = 32;
   localparam int MAXO = 2;

   logic                  clk = 1'b0;
   logic                  rst_n = 1'b0;
   logic [N-1:0]          core_req;
   logic [N-1:0][AW-1:0]  core_addr;
   logic [N-1:0]          core_gnt, core_rv;
   logic [DW-1:0]         core_rdata;
   logic                  bank_req;
   logic [AW-1:0]         bank_addr;
   logic                  bank_gnt, bank_rv;
   logic [DW-1:0]         bank_rdata;
   logic                  spur;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   icache_bank_rr_arbiter #(
      .N_CORES         (N),
      .ADDR_WIDTH      (AW),
      .DATA_WIDTH      (DW),
      .MAX_OUTSTANDING (MAXO)
   ) dut (
      .clk_i          (clk),
      .rst_ni         (rst_n),
      .core_req_i     (core_req),
      .core_addr_i    (core_addr),
      .core_gnt_o     (core_gnt),
      .core_r_valid_o (core_rv),
      .core_r_rdata_o (core_rdata),
      .bank_req_o     (bank_req),
      .bank_addr_o    (bank_addr),
      .bank_gnt_i     (bank_gnt),
      .bank_r_valid_i (bank_rv),
      .bank_r_rdata_i (bank_rdata),
      .spurious_rsp_o (spur)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: a queue of granted core IDs, a next-priority index and an optional held winner.
   int           mdl_ptr = 0;
   int           mdl_hold = -1;
   int           q[$];
   bit           mdl_spur = 1'b0;
   logic [N-1:0] mdl_gnt_last = '0;
   int           m_win;
   logic         m_req;
   logic [AW-1:0] m_addr;
   logic [N-1:0] m_gnt, m_rv;
   logic [DW-1:0] m_rdata;

   always @(negedge clk) begin
      if (!rst_n) begin
         mdl_ptr = 0; mdl_hold = -1; q.delete(); mdl_spur = 1'b0; mdl_gnt_last = '0;
         check("m_rst_bank_req", 64'(bank_req), 64'(0));
         check("m_rst_gnt", 64'(core_gnt), 64'(0));
         check("m_rst_rv", 64'(core_rv), 64'(0));
         check("m_rst_spur", 64'(spur), 64'(0));
      end else begin
         m_win = -1;
         if (mdl_hold >= 0) m_win = mdl_hold;
         else for (int i = 0; i < N; i++)
            if (m_win < 0 && core_req[(mdl_ptr + i) % N]) m_win = (mdl_ptr + i) % N;
         m_req  = (m_win >= 0) && (q.size() < MAXO);
         m_addr = (m_win >= 0) ? core_addr[m_win] : '0;
         m_gnt  = '0;
         if (m_req && bank_gnt) m_gnt[m_win] = 1'b1;
         m_rv = '0; m_rdata = '0;
         if (bank_rv && q.size() > 0) begin m_rv[q[0]] = 1'b1; m_rdata = bank_rdata; end
         check("m_bank_req", 64'(bank_req), 64'(m_req));
         check("m_bank_addr", 64'(bank_addr), 64'(m_addr));
         check("m_core_gnt", 64'(core_gnt), 64'(m_gnt));
         check("m_core_rv", 64'(core_rv), 64'(m_rv));
         check("m_core_rdata", 64'(core_rdata), 64'(m_rdata));
         check("m_spur", 64'(spur), 64'(mdl_spur));
         if (bank_rv) begin
            if (q.size() > 0) void'(q.pop_front());
            else mdl_spur = 1'b1;
         end
         if (m_gnt != '0) begin
            q.push_back(m_win);
            mdl_ptr  = (m_win + 1) % N;
            mdl_hold = -1;
         end else if (m_req) mdl_hold = m_win;
         mdl_gnt_last = m_gnt;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      core_req = '0; bank_gnt = 1'b0; bank_rv = 1'b0; bank_rdata = '0;
   endtask

   initial begin
      idle_inputs();
      for (int i = 0; i < N; i++) core_addr[i] = 32'h1000 + 32'(i * 4);
      @(negedge clk);
      check("reset_bank_req", 64'(bank_req), 64'(0));
      check("reset_spur", 64'(spur), 64'(0));
      step(); step();
      rst_n = 1'b1;

      // round robin over all cores, one response per cycle keeps the FIFO from filling
      for (int k = 0; k < 9; k++) begin
         core_req = '1; bank_gnt = 1'b1; bank_rv = (k > 0); bank_rdata = 32'(k);
         @(negedge clk);
         check("rr_gnt", 64'(core_gnt), 64'(1 << (k % 8)));
         if (k > 0) check("rr_rsp", 64'(core_rv), 64'(1 << ((k - 1) % 8)));
         step();
      end
      core_req = '0; bank_gnt = 1'b0; bank_rv = 1'b1;
      @(negedge clk); check("rr_drain", 64'(core_rv), 64'h01);
      step(); bank_rv = 1'b0;

      // lock on core 3 while the bank stalls; core 1 joins during the lock
      core_addr[3] = 32'h100; core_addr[1] = 32'h200;
      for (int c = 1; c <= 4; c++) begin
         core_req = (c == 1) ? 8'h08 : 8'h0A; bank_gnt = 1'b0;
         @(negedge clk);
         check("lock_req", 64'(bank_req), 64'(1));
         check("lock_addr", 64'(bank_addr), 64'h100);
         check("lock_no_gnt", 64'(core_gnt), 64'(0));
         step();
      end
      core_req = 8'h0A; bank_gnt = 1'b1;
      @(negedge clk); check("lock_gnt3", 64'(core_gnt), 64'h08); check("lock_addr5", 64'(bank_addr), 64'h100);
      step(); core_req = 8'h02;
      @(negedge clk); check("lock_gnt1", 64'(core_gnt), 64'h02); check("lock_addr6", 64'(bank_addr), 64'h200);
      step(); core_req = '0; bank_gnt = 1'b0; bank_rv = 1'b1;
      @(negedge clk); check("lock_rsp3", 64'(core_rv), 64'h08);
      step();
      @(negedge clk); check("lock_rsp1", 64'(core_rv), 64'h02);
      step(); bank_rv = 1'b0;

      // in-order routing: grant 2 then 5, responses follow grant order
      core_req = 8'h04; bank_gnt = 1'b1;
      @(negedge clk); check("route_gnt2", 64'(core_gnt), 64'h04);
      step(); core_req = 8'h20;
      @(negedge clk); check("route_gnt5", 64'(core_gnt), 64'h20);
      step(); core_req = '0; bank_gnt = 1'b0; bank_rv = 1'b1; bank_rdata = 32'hAAAA;
      @(negedge clk); check("route_rv2", 64'(core_rv), 64'h04); check("route_d2", 64'(core_rdata), 64'hAAAA);
      step(); bank_rdata = 32'hBBBB;
      @(negedge clk); check("route_rv5", 64'(core_rv), 64'h20); check("route_d5", 64'(core_rdata), 64'hBBBB);
      step(); bank_rv = 1'b0;

      // full FIFO blocks requests, including the cycle that pops
      core_req = 8'h13; bank_gnt = 1'b1;
      @(negedge clk); check("full_gnt0", 64'(core_gnt), 64'h01);
      step(); core_req = 8'h12;
      @(negedge clk); check("full_gnt1", 64'(core_gnt), 64'h02);
      step(); core_req = 8'h10;
      @(negedge clk); check("full_req_low", 64'(bank_req), 64'(0)); check("full_no_gnt", 64'(core_gnt), 64'(0));
      step(); bank_rv = 1'b1; bank_rdata = 32'h5;
      @(negedge clk); check("full_pop_req_low", 64'(bank_req), 64'(0)); check("full_pop_rv", 64'(core_rv), 64'h01);
      step(); bank_rv = 1'b0;
      @(negedge clk); check("full_reassert", 64'(bank_req), 64'(1)); check("full_gnt4", 64'(core_gnt), 64'h10);
      step(); core_req = '0; bank_gnt = 1'b0; bank_rv = 1'b1;
      @(negedge clk); check("full_drain1", 64'(core_rv), 64'h02);
      step();
      @(negedge clk); check("full_drain4", 64'(core_rv), 64'h10);
      step(); bank_rv = 1'b0;

      // spurious response with an empty FIFO
      bank_rv = 1'b1; bank_rdata = 32'h1234;
      @(negedge clk); check("spur_no_rv", 64'(core_rv), 64'(0)); check("spur_not_yet", 64'(spur), 64'(0));
      step(); bank_rv = 1'b0;
      @(negedge clk); check("spur_set", 64'(spur), 64'(1));
      step();
      @(negedge clk); check("spur_sticky", 64'(spur), 64'(1));
      step();

      // reset while locked with one request outstanding
      core_req = 8'h04; bank_gnt = 1'b1;
      @(negedge clk); check("rst_pre_gnt2", 64'(core_gnt), 64'h04);
      step(); core_req = 8'h40; bank_gnt = 1'b0;
      @(negedge clk); check("rst_pre_lock", 64'(bank_addr), 64'h1018);
      step(); rst_n = 1'b0; idle_inputs();
      @(negedge clk);
      check("rst_mid_req", 64'(bank_req), 64'(0)); check("rst_mid_addr", 64'(bank_addr), 64'(0));
      check("rst_mid_spur", 64'(spur), 64'(0)); check("rst_mid_rv", 64'(core_rv), 64'(0));
      step(); rst_n = 1'b1; bank_rv = 1'b1; bank_rdata = 32'h77;
      @(negedge clk); check("rst_late_rv", 64'(core_rv), 64'(0));
      step(); bank_rv = 1'b0; core_req = '1; bank_gnt = 1'b1;
      @(negedge clk); check("rst_late_spur", 64'(spur), 64'(1)); check("rst_ptr0", 64'(core_gnt), 64'h01);
      step(); core_req = '0; bank_gnt = 1'b0; bank_rv = 1'b1;
      @(negedge clk); check("rst_drain", 64'(core_rv), 64'h01);
      step(); bank_rv = 1'b0;
      step();

      // randomized traffic checked by the reference model
      for (int cyc = 0; cyc < 4000; cyc++) begin
         if ($urandom_range(0, 599) == 0) begin
            rst_n = 1'b0; idle_inputs();
            step();
            rst_n = 1'b1;
            continue;
         end
         core_req = core_req & ~mdl_gnt_last;
         for (int i = 0; i < N; i++)
            if (!core_req[i] && $urandom_range(0, 2) == 0) begin
               core_req[i]  = 1'b1;
               core_addr[i] = $urandom;
            end
         bank_gnt   = ($urandom_range(0, 1) == 1);
         bank_rv    = ($urandom_range(0, 9) < 4);
         bank_rdata = $urandom;
         step();
      end

      idle_inputs();
      step();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
